// File: rtl/free_list_if.sv
// -----------------------------------------------------------------------------
// free_list_if
//   Bundles the rename-side signals of the physical-register free list.
//
//   master : the rename/commit side (drives allocation, release, checkpoint and
//            recover requests; observes the presented free IDs and occupancy).
//   slave  : the free list itself.
//
//   Signals
//     alloc_cnt       lanes consumed this cycle, lanes 0..alloc_cnt-1
//     rel_valid       per-lane release valid, lane 0 in the MSB
//     rel_id_flatten  released IDs, lane 0 in the MSBs
//     ckpt_take       save the (next-cycle) head pointer
//     recover         restore head from the checkpoint
//     phyreg_flatten  presented free IDs, lane 0 in the MSBs
//     free_count      number of free entries
//     alloc_ready     free_count >= NUM_DECODE
// -----------------------------------------------------------------------------
interface free_list_if #(
  parameter int NUM_DECODE = 4,
  parameter int NUM_ARCH   = 31,
  parameter int NUM_PHY    = 380,
  parameter int NUM_COMMIT = 4,
  parameter int PHY_WIDTH  = 9
);
  localparam int DEPTH = NUM_PHY - NUM_ARCH;
  localparam int ACW   = $clog2(NUM_DECODE + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ACW-1:0]                   alloc_cnt;
  logic [NUM_COMMIT-1:0]            rel_valid;
  logic [PHY_WIDTH*NUM_COMMIT-1:0]  rel_id_flatten;
  logic                             ckpt_take;
  logic                             recover;
  logic [PHY_WIDTH*NUM_DECODE-1:0]  phyreg_flatten;
  logic [CNT_W-1:0]                 free_count;
  logic                             alloc_ready;

  modport master (
    output alloc_cnt, rel_valid, rel_id_flatten, ckpt_take, recover,
    input  phyreg_flatten, free_count, alloc_ready
  );

  modport slave (
    input  alloc_cnt, rel_valid, rel_id_flatten, ckpt_take, recover,
    output phyreg_flatten, free_count, alloc_ready
  );
endinterface

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list for the rename stage. A circular queue of
//   DEPTH = NUM_PHY - NUM_ARCH entries holds the free physical register IDs.
//   The first NUM_DECODE entries from head are presented every cycle; rename
//   pops alloc_cnt of them. Committed IDs are appended at tail. A single head
//   checkpoint allows branch-mispredict recovery.
//
//   Ports
//     clk  : clock, all state updates on posedge
//     rst  : synchronous active-high reset
//     fl   : free_list_if.slave (see interface header for signal meanings)
//
//   Notes
//     - DEPTH is not a power of two, so every pointer add wraps explicitly.
//     - Lane outputs depend only on registered state (no input-to-output path).
//     - The queue is a register array rather than block RAM because
//       NUM_DECODE entries must be read in the same cycle they are requested.
// -----------------------------------------------------------------------------
module free_list #(
  parameter int NUM_DECODE = 4,
  parameter int NUM_ARCH   = 31,
  parameter int NUM_PHY    = 380,
  parameter int NUM_COMMIT = 4,
  parameter int PHY_WIDTH  = 9
) (
  input  logic          clk,
  input  logic          rst,
  free_list_if.slave    fl
);

  localparam int DEPTH = NUM_PHY - NUM_ARCH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ACW   = $clog2(NUM_DECODE + 1);
  localparam int RCW   = $clog2(NUM_COMMIT + 1);
  localparam int SUM_W = CNT_W + 2;

  typedef logic [PTR_W-1:0] ptr_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PHY_WIDTH-1:0] queue_reg [DEPTH];
  ptr_t                 head_reg;
  ptr_t                 tail_reg;
  ptr_t                 ckpt_head_reg;
  logic [CNT_W-1:0]     count_reg;

  ptr_t                 head_next;
  ptr_t                 tail_next;
  ptr_t                 ckpt_head_next;
  logic [CNT_W-1:0]     count_next;

  // Modulo-DEPTH add; inc is always smaller than DEPTH so one subtract suffices.
  function automatic ptr_t ptr_add(input ptr_t base, input ptr_t inc);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum >= (PTR_W+1)'(DEPTH)) begin
      sum = sum - (PTR_W+1)'(DEPTH);
    end
    return sum[PTR_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Release lane decode. rel_valid and rel_id_flatten both carry lane 0 in
  // their most significant position.
  // ---------------------------------------------------------------------------
  logic                 rel_v    [NUM_COMMIT];
  logic [PHY_WIDTH-1:0] rel_id   [NUM_COMMIT];
  ptr_t                 rel_off  [NUM_COMMIT];
  ptr_t                 rel_addr [NUM_COMMIT];
  logic [RCW-1:0]       rel_num;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COMMIT; gi++) begin : g_rel
      assign rel_v[gi]    = fl.rel_valid[NUM_COMMIT-1-gi];
      assign rel_id[gi]   = fl.rel_id_flatten[PHY_WIDTH*(NUM_COMMIT-gi)-1 -: PHY_WIDTH];
      assign rel_addr[gi] = ptr_add(tail_reg, rel_off[gi]);
    end
  endgenerate

  // Compaction: each valid lane's slot offset is the number of valid lanes
  // ahead of it, so valid IDs land contiguously at tail, tail+1, ...
  always_comb begin
    rel_num = '0;
    rel_off = '{default: '0};
    for (int j = 0; j < NUM_COMMIT; j++) begin
      rel_off[j] = ptr_t'(rel_num);
      rel_num    = rel_num + RCW'(rel_v[j]);
    end
  end

  // ---------------------------------------------------------------------------
  // Head / count / checkpoint next-state
  // ---------------------------------------------------------------------------
  logic             alloc_ok;
  logic [CNT_W-1:0] restored;
  logic [SUM_W-1:0] count_sum;

  // Entries popped since the checkpoint; arithmetic in PTR_W bits is exact
  // because the true result is always below DEPTH.
  always_comb begin
    if (head_reg >= ckpt_head_reg) begin
      restored = CNT_W'(head_reg - ckpt_head_reg);
    end else begin
      restored = CNT_W'(head_reg + ptr_t'(DEPTH) - ckpt_head_reg);
    end
  end

  always_comb begin
    alloc_ok  = !fl.recover && (CNT_W'(fl.alloc_cnt) <= count_reg);
    head_next = head_reg;
    count_sum = SUM_W'(count_reg) + SUM_W'(rel_num);

    if (fl.recover) begin
      // Recovery drops this cycle's allocation; releases still land.
      head_next = ckpt_head_reg;
      count_sum = count_sum + SUM_W'(restored);
    end else if (alloc_ok) begin
      head_next = ptr_add(head_reg, ptr_t'(fl.alloc_cnt));
      count_sum = count_sum - SUM_W'(fl.alloc_cnt);
    end

    count_next     = CNT_W'(count_sum);
    tail_next      = ptr_add(tail_reg, ptr_t'(rel_num));
    // The checkpoint captures the head as it will be next cycle, which makes
    // ckpt_take together with recover save the restored head.
    ckpt_head_next = fl.ckpt_take ? head_next : ckpt_head_reg;
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        queue_reg[i] <= PHY_WIDTH'(NUM_ARCH + i);
      end
      head_reg      <= '0;
      tail_reg      <= '0;
      ckpt_head_reg <= '0;
      count_reg     <= CNT_W'(DEPTH);
    end else begin
      // Compacted addresses are distinct, so the writes never collide.
      for (int j = 0; j < NUM_COMMIT; j++) begin
        if (rel_v[j]) begin
          queue_reg[rel_addr[j]] <= rel_id[j];
        end
      end
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      ckpt_head_reg <= ckpt_head_next;
      count_reg     <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Presented lanes: queue[head+k] while k < count, else 0.
  // ---------------------------------------------------------------------------
  logic [PHY_WIDTH*NUM_DECODE-1:0] phyreg;

  generate
    for (gi = 0; gi < NUM_DECODE; gi++) begin : g_lane
      ptr_t rd_addr;
      assign rd_addr = ptr_add(head_reg, ptr_t'(gi));
      assign phyreg[PHY_WIDTH*(NUM_DECODE-gi)-1 -: PHY_WIDTH] =
        (CNT_W'(gi) < count_reg) ? queue_reg[rd_addr] : '0;
    end
  endgenerate

  assign fl.phyreg_flatten = phyreg;
  assign fl.free_count     = count_reg;
  assign fl.alloc_ready    = (count_reg >= CNT_W'(NUM_DECODE));

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
//   Directed bench for free_list. A queue-based model of the free list (plus
//   the list of IDs popped since the last checkpoint) supplies the expected
//   lanes and count after every step; key points are also compared against
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_free_list;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  free_list_if bus ();

  free_list dut (
    .clk (clk),
    .rst (rst),
    .fl  (bus)
  );

  int checks;
  int errors;
  int mdl[$];     // free IDs in allocation order
  int saved[$];   // IDs popped since the last checkpoint, oldest first

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] exp_lanes();
    logic [35:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < mdl.size()) v[9*(4-k)-1 -: 9] = 9'(mdl[k]);
    end
    return v;
  endfunction

  task automatic model_reset();
    mdl.delete();
    saved.delete();
    for (int i = 0; i < 349; i++) mdl.push_back(31 + i);
  endtask

  task automatic model_step(input int a, input logic [3:0] rv, input logic [35:0] ids,
                            input bit ck, input bit rec);
    if (rec) begin
      for (int i = saved.size() - 1; i >= 0; i--) mdl.push_front(saved[i]);
      saved.delete();
    end else if (a <= mdl.size()) begin
      repeat (a) saved.push_back(mdl.pop_front());
    end
    for (int k = 0; k < 4; k++) begin
      if (rv[3-k]) mdl.push_back(int'(ids[9*(4-k)-1 -: 9]));
    end
    if (ck) saved.delete();
    chk("no_overflow", 64'(mdl.size() <= 349), 64'd1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_lanes"}, 64'(bus.phyreg_flatten), 64'(exp_lanes()));
    chk({tag, "_count"}, 64'(bus.free_count), 64'(mdl.size()));
    chk({tag, "_ready"}, 64'(bus.alloc_ready), 64'(mdl.size() >= 4));
  endtask

  task automatic step(input string tag, input int a, input logic [3:0] rv,
                      input logic [35:0] ids, input bit ck, input bit rec);
    bus.alloc_cnt      = 3'(a);
    bus.rel_valid      = rv;
    bus.rel_id_flatten = ids;
    bus.ckpt_take      = ck;
    bus.recover        = rec;
    @(posedge clk);
    #1;
    model_step(a, rv, ids, ck, rec);
    $display("step %s alloc=%0d rel=%b ckpt=%0d rec=%0d -> free_count=%0d lanes=%0h",
             tag, a, rv, ck, rec, bus.free_count, bus.phyreg_flatten);
    check_state(tag);
  endtask

  logic [35:0] ids;
  logic [35:0] ckpt_lanes;

  initial begin
    checks = 0;
    errors = 0;
    bus.alloc_cnt      = '0;
    bus.rel_valid      = '0;
    bus.rel_id_flatten = '0;
    bus.ckpt_take      = 1'b0;
    bus.recover        = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state
    chk("reset_lanes", 64'(bus.phyreg_flatten), 64'({9'd31, 9'd32, 9'd33, 9'd34}));
    chk("reset_count", 64'(bus.free_count), 64'd349);
    chk("reset_ready", 64'(bus.alloc_ready), 64'd1);
    step("idle", 0, 4'b0000, '0, 1'b0, 1'b0);

    // First allocation
    step("alloc3", 3, 4'b0000, '0, 1'b0, 1'b0);
    chk("alloc3_lanes_k", 64'(bus.phyreg_flatten), 64'({9'd34, 9'd35, 9'd36, 9'd37}));
    chk("alloc3_count_k", 64'(bus.free_count), 64'd346);

    // Drain to one entry
    for (int i = 0; i < 86; i++) step("drain", 4, 4'b0000, '0, 1'b0, 1'b0);
    step("drain_last", 1, 4'b0000, '0, 1'b0, 1'b0);
    chk("count1_lanes_k", 64'(bus.phyreg_flatten), 64'({9'd379, 9'd0, 9'd0, 9'd0}));
    chk("count1_ready_k", 64'(bus.alloc_ready), 64'd0);
    step("over_alloc", 4, 4'b0000, '0, 1'b0, 1'b0);
    chk("over_alloc_count_k", 64'(bus.free_count), 64'd1);
    step("empty", 1, 4'b0000, '0, 1'b0, 1'b0);
    chk("empty_lanes_k", 64'(bus.phyreg_flatten), 64'd0);
    chk("empty_count_k", 64'(bus.free_count), 64'd0);

    // Release compaction at wrapped tail, no same-cycle bypass
    ids = {9'd5, 9'd0, 9'd7, 9'd0};
    bus.alloc_cnt      = '0;
    bus.rel_valid      = 4'b1010;
    bus.rel_id_flatten = ids;
    #1;
    chk("no_bypass_lanes", 64'(bus.phyreg_flatten), 64'd0);
    step("compact", 0, 4'b1010, ids, 1'b0, 1'b0);
    chk("compact_lanes_k", 64'(bus.phyreg_flatten), 64'({9'd5, 9'd7, 9'd0, 9'd0}));
    chk("compact_count_k", 64'(bus.free_count), 64'd2);

    // Refill with IDs 100..119
    for (int c = 0; c < 5; c++) begin
      ids = {9'(100 + 4*c), 9'(101 + 4*c), 9'(102 + 4*c), 9'(103 + 4*c)};
      step("refill", 0, 4'b1111, ids, 1'b0, 1'b0);
    end

    // Checkpoint at head=10, allocate 8, recover
    step("adv", 4, 4'b0000, '0, 1'b0, 1'b0);
    step("adv", 4, 4'b0000, '0, 1'b0, 1'b0);
    step("adv", 2, 4'b0000, '0, 1'b0, 1'b0);
    step("ckpt", 0, 4'b0000, '0, 1'b1, 1'b0);
    chk("ckpt_lanes_k", 64'(bus.phyreg_flatten), 64'({9'd108, 9'd109, 9'd110, 9'd111}));
    chk("ckpt_count_k", 64'(bus.free_count), 64'd12);
    step("spec_alloc", 4, 4'b0000, '0, 1'b0, 1'b0);
    step("spec_alloc", 4, 4'b0000, '0, 1'b0, 1'b0);
    chk("spec_lanes_k", 64'(bus.phyreg_flatten), 64'({9'd116, 9'd117, 9'd118, 9'd119}));
    chk("count4_ready_k", 64'(bus.alloc_ready), 64'd1);
    step("recover", 0, 4'b0000, '0, 1'b0, 1'b1);
    chk("recover_lanes_k", 64'(bus.phyreg_flatten), 64'({9'd108, 9'd109, 9'd110, 9'd111}));
    chk("recover_count_k", 64'(bus.free_count), 64'd12);

    // Wrap: alloc 4 and release the same 4 IDs for 200 cycles
    for (int i = 0; i < 200; i++) begin
      ids = exp_lanes();
      step("wrap", 4, 4'b1111, ids, 1'b0, 1'b0);
    end
    chk("wrap_count_k", 64'(bus.free_count), 64'd12);

    // Simultaneous recover + alloc + release + ckpt_take
    step("ckpt2", 0, 4'b0000, '0, 1'b1, 1'b0);
    ckpt_lanes = exp_lanes();
    step("spec_alloc2", 3, 4'b0000, '0, 1'b0, 1'b0);
    step("simul", 2, 4'b0100, {9'd0, 9'd200, 9'd0, 9'd0}, 1'b1, 1'b1);
    chk("simul_lanes", 64'(bus.phyreg_flatten), 64'(ckpt_lanes));
    chk("simul_count_k", 64'(bus.free_count), 64'd13);
    step("spec_alloc3", 2, 4'b0000, '0, 1'b0, 1'b0);
    step("recover2", 0, 4'b0000, '0, 1'b0, 1'b1);
    chk("recover2_lanes", 64'(bus.phyreg_flatten), 64'(ckpt_lanes));
    chk("recover2_count_k", 64'(bus.free_count), 64'd13);

    // Reset mid-sequence with every request pending
    bus.alloc_cnt      = 3'd2;
    bus.rel_valid      = 4'b1000;
    bus.rel_id_flatten = {9'd77, 9'd0, 9'd0, 9'd0};
    bus.ckpt_take      = 1'b1;
    bus.recover        = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    $display("step mid_reset -> free_count=%0d lanes=%0h", bus.free_count, bus.phyreg_flatten);
    chk("mid_reset_lanes_k", 64'(bus.phyreg_flatten), 64'({9'd31, 9'd32, 9'd33, 9'd34}));
    chk("mid_reset_count_k", 64'(bus.free_count), 64'd349);
    chk("mid_reset_ready_k", 64'(bus.alloc_ready), 64'd1);
    step("post_reset", 4, 4'b0000, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
